// File: rtl/memory_line_bridge_pkg.sv
// Shared types and size helpers for the cache-line to word-beat memory bridge.
package memory_line_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int beats_f(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  function automatic int offset_bits_f(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int beat_idx_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEFAULT_BEAT_IDX_W = beat_idx_w_f(beats_f(128, 32));

endpackage

// File: rtl/memory_line_bridge.sv
// Serializes one arbiter line request into word beats on a req/ack port.
// Optional ack watchdog: define MEMORY_LINE_BRIDGE_TIMEOUT_EN.
module memory_line_bridge
  import memory_line_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memEnable,
  input  logic                  memIsWrite,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [LINE_WIDTH-1:0] memWriteValue,
  output logic [LINE_WIDTH-1:0] memReadValue,
  output logic                  memDone,
  output logic                  memError,
  output logic                  extReq,
  output logic                  extWrite,
  output logic [ADDR_WIDTH-1:0] extAddr,
  output logic [WORD_WIDTH-1:0] extWriteData,
  input  logic                  extAck,
  input  logic [WORD_WIDTH-1:0] extReadData,
  output state_t                fsm_state
);

  localparam int BEATS       = beats_f(LINE_WIDTH, WORD_WIDTH);
  localparam int OFFSET_BITS = offset_bits_f(LINE_WIDTH);
  localparam int BW          = beat_idx_w_f(BEATS);
  localparam int BYTE_SHIFT  = $clog2(WORD_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                state, state_next;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] base;
  logic                  is_write;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] buffer;
  logic                  busy;
  logic                  last_beat;
  logic                  timeout_hit;

  assign busy      = (state == ST_BUSY);
  assign last_beat = (beat == BW'(BEATS - 1));

`ifdef MEMORY_LINE_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wait_cnt;
  logic          err;

  assign timeout_hit = busy && !extAck && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_IDLE && memEnable) begin
        wait_cnt <= '0;
      end else if (busy) begin
        if (extAck) wait_cnt <= '0;
        else if (!timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) err <= 1'b1;
      else if (state == ST_DONE) err <= 1'b0;
    end
  end

  assign memError = err;
`else
  assign timeout_hit = 1'b0;
  assign memError    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (memEnable) state_next = ST_BUSY;
      ST_BUSY: if ((extAck && last_beat) || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured in Idle, so arbiter-side changes mid-access are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      base     <= '0;
      is_write <= 1'b0;
      wdata    <= '0;
      buffer   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memEnable) begin
            base     <= memAddr & ~OFFSET_MASK;
            is_write <= memIsWrite;
            wdata    <= memWriteValue;
            beat     <= '0;
          end
        end
        ST_BUSY: begin
          if (extAck) begin
            if (!is_write) buffer[beat*WORD_WIDTH +: WORD_WIDTH] <= extReadData;
            if (!last_beat) beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat handshake: extReq holds with stable fields until the cycle extAck is
  // high; that cycle completes the beat and carries read data on extReadData.
  assign extReq       = busy;
  assign extWrite     = busy & is_write;
  assign extAddr      = busy ? base + (ADDR_WIDTH'(beat) << BYTE_SHIFT) : '0;
  assign extWriteData = busy ? wdata[beat*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign memDone      = (state == ST_DONE);
  assign memReadValue = buffer;
  assign fsm_state    = state;

endmodule
